// File: rtl/rr_grant_scheduler_pkg.sv
// Shared constants and helpers for the round-robin grant scheduler.
package rr_grant_scheduler_pkg;

    localparam int unsigned RR_DEFAULT_NUM_REQ = 4;

    // Next requester index after idx, wrapping to 0 past num-1.
    function automatic int unsigned rr_next_idx(input int unsigned idx, input int unsigned num);
        return ((idx + 1) >= num) ? 0 : (idx + 1);
    endfunction

endpackage

// File: rtl/decoder_no_valid.sv
// Binary-to-one-hot decoder without an enable; selects >= NUM_WIRE decode to all zero.
module decoder_no_valid #(
    parameter  int unsigned NUM_WIRE = 4,
    localparam int unsigned SEL_W    = (NUM_WIRE > 1) ? $clog2(NUM_WIRE) : 1
) (
    input  logic [SEL_W-1:0]    sel_i,
    output logic [NUM_WIRE-1:0] onehot_o
);

    // One-hot decode of the select index.
    always_comb begin
        onehot_o = '0;
        for (int unsigned i = 0; i < NUM_WIRE; i++) begin
            if (sel_i == SEL_W'(i)) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler sharing one downstream resource between NUM_REQ requesters,
// holding the offered grant stable until the valid/ready handshake completes.
module rr_grant_scheduler
    import rr_grant_scheduler_pkg::*;
#(
    parameter  int unsigned NUM_REQ = RR_DEFAULT_NUM_REQ,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               arst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_valid_o,
    input  logic               gnt_ready_i
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Requester count at one extra bit, so ptr+offset never overflows before wrapping.
    localparam logic [IDX_W:0] NUM_REQ_X = (IDX_W+1)'(NUM_REQ);

    state_t             state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   locked_idx_q;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_valid;
    logic [NUM_REQ-1:0] dec_onehot;

    // Reject degenerate configurations at elaboration.
    if (NUM_REQ < 2) begin : g_bad_num_req
        $fatal(1, "rr_grant_scheduler: NUM_REQ must be >= 2");
    end

    // Rotating priority search: first requesting index at or after ptr, wrapping.
    always_comb begin
        logic [IDX_W:0] cand;
        sel_idx   = '0;
        sel_valid = 1'b0;
        cand      = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(off);
            if (cand >= NUM_REQ_X) begin
                cand = cand - NUM_REQ_X;
            end
            if (!sel_valid && req_i[cand[IDX_W-1:0]]) begin
                sel_valid = 1'b1;
                sel_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Grant offer: held index while locked, live arbitration while idle, silent in reset.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        if (state_q == LOCKED) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = locked_idx_q;
        end else if (sel_valid && arst_ni) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = sel_idx;
        end
    end

    decoder_no_valid #(
        .NUM_WIRE (NUM_REQ)
    ) u_dec (
        .sel_i    (gnt_idx_o),
        .onehot_o (dec_onehot)
    );

    assign gnt_o = dec_onehot & {NUM_REQ{gnt_valid_o}};

    // Handshake FSM: advance the pointer past each accepted grant, lock under backpressure.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            locked_idx_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_valid) begin
                        if (gnt_ready_i) begin
                            ptr_q <= IDX_W'(rr_next_idx(32'(sel_idx), NUM_REQ));
                        end else begin
                            locked_idx_q <= sel_idx;
                            state_q      <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (gnt_ready_i) begin
                        ptr_q   <= IDX_W'(rr_next_idx(32'(locked_idx_q), NUM_REQ));
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
